// File: rtl/long_divider_if.sv
// Handshake and data bundle for the sequential long divider.
// The DUT takes the slave view; a requester (testbench or upstream block) takes the master view.
interface long_divider_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  data_valid_i;
    logic [DATA_WIDTH-1:0] quotient_o;
    logic [DATA_WIDTH-1:0] remainder_o;
    logic                  data_valid_o;
    logic                  divide_by_zero_o;
    logic                  idle_o;

    modport slave (
        input  dividend_i,
        input  divisor_i,
        input  data_valid_i,
        output quotient_o,
        output remainder_o,
        output data_valid_o,
        output divide_by_zero_o,
        output idle_o
    );

    modport master (
        output dividend_i,
        output divisor_i,
        output data_valid_i,
        input  quotient_o,
        input  remainder_o,
        input  data_valid_o,
        input  divide_by_zero_o,
        input  idle_o
    );
endinterface

// File: rtl/long_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to the result cycle with an all-ones quotient.
module long_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    long_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] quotient_r;
    logic [DATA_WIDTH-1:0] remainder_r;
    logic                  data_valid_r;
    logic                  dbz_r;
    logic                  idle_r;

    logic                  zero_div_s;
    logic                  last_s;
    logic                  qbit_s;
    logic [DATA_WIDTH:0]   shifted_s;
    logic [DATA_WIDTH-1:0] diff_lo_s;
    logic [DATA_WIDTH-1:0] rem_next_s;
    logic [DATA_WIDTH-1:0] quo_next_s;

    // Trial subtraction for the current iteration.
    // shreg_r doubles as the dividend shifter and the quotient accumulator.
    always_comb begin
        zero_div_s = (bus.divisor_i == {DATA_WIDTH{1'b0}});
        last_s     = (cnt_r == CNT_LAST);
        shifted_s  = {rem_r, shreg_r[DATA_WIDTH-1]};
        qbit_s     = (shifted_s >= {1'b0, dvs_r});
        // A successful difference is below the divisor, so the low bits are exact.
        diff_lo_s  = shifted_s[DATA_WIDTH-1:0] - dvs_r;
        if (qbit_s) begin
            rem_next_s = diff_lo_s;
        end else begin
            rem_next_s = shifted_s[DATA_WIDTH-1:0];
        end
        quo_next_s = {shreg_r[DATA_WIDTH-2:0], qbit_s};
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.data_valid_i) begin
                    if (zero_div_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = DIVIDE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DIVIDE: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DIVIDE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Working datapath and registered results.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rem_r        <= {DATA_WIDTH{1'b0}};
            shreg_r      <= {DATA_WIDTH{1'b0}};
            dvs_r        <= {DATA_WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            quotient_r   <= {DATA_WIDTH{1'b0}};
            remainder_r  <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            dbz_r        <= 1'b0;
            idle_r       <= 1'b1;
        end else begin
            data_valid_r <= (next_state_s == DONE);
            idle_r       <= (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (bus.data_valid_i && zero_div_s) begin
                        quotient_r  <= {DATA_WIDTH{1'b1}};
                        remainder_r <= bus.dividend_i;
                        dbz_r       <= 1'b1;
                    end else if (bus.data_valid_i) begin
                        shreg_r <= bus.dividend_i;
                        dvs_r   <= bus.divisor_i;
                        rem_r   <= {DATA_WIDTH{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                DIVIDE: begin
                    rem_r   <= rem_next_s;
                    shreg_r <= quo_next_s;
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        quotient_r  <= quo_next_s;
                        remainder_r <= rem_next_s;
                        dbz_r       <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.quotient_o       = quotient_r;
    assign bus.remainder_o      = remainder_r;
    assign bus.data_valid_o     = data_valid_r;
    assign bus.divide_by_zero_o = dbz_r;
    assign bus.idle_o           = idle_r;

endmodule

// File: doc/long_divider.md
LONG_DIVIDER -- requirements
Module: long_divider

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand/result word width; SHALL be a power of 2, >= 4.
REQ-002 clk_i  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 dividend_i  input  DATA_WIDTH  unsigned dividend, sampled only on the accepting edge.
REQ-005 divisor_i  input  DATA_WIDTH  unsigned divisor, sampled only on the accepting edge.
REQ-006 data_valid_i  input  1  start request.
REQ-007 quotient_o  output  DATA_WIDTH  registered quotient.
REQ-008 remainder_o  output  DATA_WIDTH  registered remainder.
REQ-009 data_valid_o  output  1  one-cycle result strobe.
REQ-010 divide_by_zero_o  output  1  registered flag, valid with data_valid_o.
REQ-011 idle_o  output  1  high when a new request can be accepted.

Function
REQ-012 Unsigned restoring division, one quotient bit per clock, MSB first; inverse of the combinational long multiplier: quotient_o * divisor + remainder_o == dividend, remainder_o < divisor.
REQ-013 FSM states: IDLE, DIVIDE, DONE; idle_o SHALL be 1 only in IDLE.
REQ-014 IDLE & data_valid_i=1 & divisor_i!=0 -> latch operands, clear partial remainder and iteration counter, go to DIVIDE.
REQ-015 IDLE & data_valid_i=1 & divisor_i=0 -> go to DONE directly; quotient_o SHALL be all ones, remainder_o SHALL be dividend_i, divide_by_zero_o SHALL be 1.
REQ-016 DIVIDE per edge: partial remainder shifted left one bit, next dividend bit shifted in; trial subtract of the divisor at DATA_WIDTH+1 bits; non-negative -> keep difference, quotient bit 1; negative -> restore, quotient bit 0.
REQ-017 Iteration counter SHALL be log2(DATA_WIDTH) bits; DIVIDE SHALL last exactly DATA_WIDTH cycles, then go to DONE.
REQ-018 Latency: data_valid_o SHALL be high in the cycle following the DATA_WIDTH-th edge after the accepting edge (divide-by-zero: the cycle following the first edge).
REQ-019 DONE lasts exactly one cycle, data_valid_o=1, then IDLE unconditionally.
REQ-020 data_valid_i while in DIVIDE or DONE SHALL be ignored (no queuing); operand changes mid-operation SHALL NOT affect the result.
REQ-021 quotient_o, remainder_o, divide_by_zero_o SHALL hold their values from DONE until the next DONE.
REQ-022 divide_by_zero_o SHALL be 0 for any non-zero divisor.
REQ-023 Back-to-back: a request in the first IDLE cycle after DONE SHALL be accepted; minimum issue interval DATA_WIDTH+2 cycles.
REQ-024 No combinational path from any input to any output.

Reset
REQ-025 rst_n_i=0 at an edge SHALL force IDLE, quotient_o=0, remainder_o=0, data_valid_o=0, divide_by_zero_o=0, counter=0; idle_o=1 from the next cycle.
REQ-026 Reset during DIVIDE or DONE SHALL abort the operation; no data_valid_o pulse for the aborted operation.
REQ-027 data_valid_i SHALL be ignored on an edge where rst_n_i=0.

Verification (DATA_WIDTH=8)
REQ-028 dividend=100, divisor=7 -> 8 edges later data_valid_o=1, quotient_o=14, remainder_o=2, divide_by_zero_o=0, idle_o low for the whole operation.
REQ-029 255/1 -> quotient_o=255, remainder_o=0; 5/9 -> quotient_o=0, remainder_o=5; 200/200 -> quotient_o=1, remainder_o=0.
REQ-030 42/0 -> next cycle data_valid_o=1, quotient_o=0xFF, remainder_o=42, divide_by_zero_o=1; following 10/3 -> quotient_o=3, remainder_o=1, divide_by_zero_o=0.
REQ-031 Start 100/7, pulse data_valid_i with 9/3 at cycle 4 of DIVIDE -> single result 14 r2, no second strobe.
REQ-032 Start 100/7, assert rst_n_i=0 at cycle 3 of DIVIDE -> all outputs 0, idle_o=1, no strobe; then 50/6 -> quotient_o=8, remainder_o=2.
REQ-033 Random sweep of 10k operand pairs incl. 0 and 255, back-to-back issue -> every result matches the reference model and REQ-012.
